// File: rtl/cpu_pkg.sv
// Shared fetch-path types: default PC geometry and the per-edge PC action code.
// Pure declarations; no logic, no latency, no flow control.
package cpu_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_INIT_VAL = '0;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INC,
      PC_LOAD,
      PC_CALL,
      PC_RET
   } pc_action_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control-unit to PC-unit bundle: control strobes and jump target in, PC and RAS status out.
// Wires only; the control unit is the master, pc_unit the slave; no backpressure.
interface pc_unit_if
   import cpu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             stall;
   logic             IncPC;
   logic             PC_enable;
   logic             PC_cond_enable;
   logic             conOut;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] BusMuxOut;
   logic [WIDTH-1:0] PC_data_out;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_overflow;
   logic             ras_underflow;

   modport master (
      output stall, IncPC, PC_enable, PC_cond_enable, conOut, call, ret, BusMuxOut,
      input  PC_data_out, ras_empty, ras_full, ras_overflow, ras_underflow
   );

   modport slave (
      input  stall, IncPC, PC_enable, PC_cond_enable, conOut, call, ret, BusMuxOut,
      output PC_data_out, ras_empty, ras_full, ras_overflow, ras_underflow
   );

endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack; push/pop land on the falling edge, top_data reads combinationally.
// Latency 1 edge; never stalls: push-when-full overwrites oldest, pop-when-empty is a no-op (sticky flags).
module ras_stack #(
   parameter int WIDTH     = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top_data,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   logic [WIDTH-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_inc;
   logic [PTR_W-1:0] ptr_dec;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic             unf_q;

   // ptr_q is the next free slot; the top entry sits one below it.
   assign ptr_inc  = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
   assign ptr_dec  = (ptr_q == '0) ? PTR_MAX : ptr_q - PTR_W'(1);
   assign top_data = mem[ptr_dec];
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CNT_MAX);
   assign ovf      = ovf_q;
   assign unf      = unf_q;

   always_ff @(negedge clock) begin
      if (!reset && push && !pop) begin
         mem[ptr_q] <= push_data;
      end
   end

   always_ff @(negedge clock) begin
      if (reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (pop) begin
         if (cnt_q == '0) begin
            unf_q <= 1'b1;
         end else begin
            ptr_q <= ptr_dec;
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end else if (push) begin
         ptr_q <= ptr_inc;
         if (cnt_q == CNT_MAX) begin
            ovf_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with increment, jump/branch load, stall and one-cycle call/ret via a RAS.
// Latency: every action lands on the falling edge it is sampled; no backpressure, stall freezes all state.
module pc_unit
   import cpu_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] INIT_VAL  = WIDTH'(DEFAULT_INIT_VAL),
   parameter int unsigned      STEP      = 1,
   parameter int               RAS_DEPTH = 4
) (
   input  logic     clock,
   input  logic     reset,
   pc_unit_if.slave bus
);

   pc_action_e       action;
   logic             taken;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] top_data;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_ovf;
   logic             ras_unf;

   // Explicit == 1'b1 keeps an X strobe from selecting an action.
   always_comb begin
      taken  = (bus.PC_enable == 1'b1) ||
               ((bus.PC_cond_enable == 1'b1) && (bus.conOut == 1'b1));
      action = PC_HOLD;
      if (bus.stall == 1'b1) begin
         action = PC_HOLD;
      end else if (bus.ret == 1'b1) begin
         action = PC_RET;
      end else if (taken) begin
         action = (bus.call == 1'b1) ? PC_CALL : PC_LOAD;
      end else if (bus.IncPC == 1'b1) begin
         action = PC_INC;
      end
   end

   always_comb begin
      pc_d = pc_q;
      case (action)
         PC_INC:           pc_d = pc_q + WIDTH'(STEP);
         PC_LOAD, PC_CALL: pc_d = bus.BusMuxOut;
         PC_RET:           pc_d = ras_empty ? pc_q : top_data;
         default:          pc_d = pc_q;
      endcase
   end

   always_ff @(negedge clock) begin
      if (reset) begin
         pc_q <= INIT_VAL;
      end else begin
         pc_q <= pc_d;
      end
   end

   ras_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clock     (clock),
      .reset     (reset),
      .push      (action == PC_CALL),
      .pop       (action == PC_RET),
      .push_data (pc_q),
      .top_data  (top_data),
      .empty     (ras_empty),
      .full      (ras_full),
      .ovf       (ras_ovf),
      .unf       (ras_unf)
   );

   assign bus.PC_data_out   = pc_q;
   assign bus.ras_empty     = ras_empty;
   assign bus.ras_full      = ras_full;
   assign bus.ras_overflow  = ras_ovf;
   assign bus.ras_underflow = ras_unf;

endmodule

// File: tb/tb_pc_unit.sv
// Scenario bench for pc_unit: a 32-bit/INIT 0x100 instance and an 8-bit instance for wrap.
module tb_pc_unit;

   localparam logic [7:0] C_RST = 8'h80;
   localparam logic [7:0] C_STL = 8'h40;
   localparam logic [7:0] C_RET = 8'h20;
   localparam logic [7:0] C_CAL = 8'h10;
   localparam logic [7:0] C_PEN = 8'h08;
   localparam logic [7:0] C_PCE = 8'h04;
   localparam logic [7:0] C_CON = 8'h02;
   localparam logic [7:0] C_INC = 8'h01;
   localparam logic [7:0] C_NOP = 8'h00;

   // flag order {empty, full, overflow, underflow}
   localparam logic [3:0] F_0 = 4'b0000;
   localparam logic [3:0] F_E = 4'b1000;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  fl;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   pc_unit_if #(.WIDTH(32)) bus32 ();
   pc_unit_if #(.WIDTH(8))  bus8 ();

   pc_unit #(.WIDTH(32), .INIT_VAL(32'h100), .STEP(1), .RAS_DEPTH(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus32)
   );

   pc_unit #(.WIDTH(8), .INIT_VAL(8'h00), .STEP(1), .RAS_DEPTH(4)) dut8 (
      .clock (clock),
      .reset (reset),
      .bus   (bus8)
   );

   logic [3:0] fl32;
   logic [3:0] fl8;
   assign fl32 = {bus32.ras_empty, bus32.ras_full, bus32.ras_overflow, bus32.ras_underflow};
   assign fl8  = {bus8.ras_empty, bus8.ras_full, bus8.ras_overflow, bus8.ras_underflow};

   always #5 clock = ~clock;

   // Called at a rising edge: drive, let the falling edge act, return at the next rising edge.
   task automatic cyc(input logic [7:0] c, input logic [31:0] d);
      reset                = c[7];
      bus32.stall          = c[6];
      bus32.ret            = c[5];
      bus32.call           = c[4];
      bus32.PC_enable      = c[3];
      bus32.PC_cond_enable = c[2];
      bus32.conOut         = c[1];
      bus32.IncPC          = c[0];
      bus32.BusMuxOut      = d;
      bus8.stall           = c[6];
      bus8.ret             = c[5];
      bus8.call            = c[4];
      bus8.PC_enable       = c[3];
      bus8.PC_cond_enable  = c[2];
      bus8.conOut          = c[1];
      bus8.IncPC           = c[0];
      bus8.BusMuxOut       = d[7:0];
      @(negedge clock);
      @(posedge clock);
   endtask

   task automatic test_reset();
      logic [7:0]  c [4];
      logic [31:0] p [4];
      exp_t e;
      c = '{C_RST, C_INC, C_INC, C_INC};
      p = '{32'h100, 32'h101, 32'h102, 32'h103};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{pc: p[i], fl: F_E});
         cyc(c[i], 32'h0);
         e = exp_q.pop_front();
         checks++;
         if (bus32.PC_data_out !== e.pc) begin
            errors++;
            $display("FAIL reset_inc[%0d] pc: got %h want %h", i, bus32.PC_data_out, e.pc);
         end
         checks++;
         if (fl32 !== e.fl) begin
            errors++;
            $display("FAIL reset_inc[%0d] flags: got %b want %b", i, fl32, e.fl);
         end
      end
   endtask

   task automatic test_branch();
      logic [7:0]  c [5];
      logic [31:0] d [5];
      logic [31:0] p [5];
      exp_t e;
      c = '{C_PEN, C_PCE | C_INC, C_PCE | C_CON | C_INC, C_PCE, C_PEN};
      d = '{32'h10, 32'h40, 32'h40, 32'h77, 32'h55};
      p = '{32'h10, 32'h11, 32'h40, 32'h40, 32'h55};
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back('{pc: p[i], fl: F_E});
         cyc(c[i], d[i]);
         e = exp_q.pop_front();
         checks++;
         if (bus32.PC_data_out !== e.pc) begin
            errors++;
            $display("FAIL branch[%0d] pc: got %h want %h", i, bus32.PC_data_out, e.pc);
         end
         checks++;
         if (fl32 !== e.fl) begin
            errors++;
            $display("FAIL branch[%0d] flags: got %b want %b", i, fl32, e.fl);
         end
      end
   endtask

   task automatic test_call_ret();
      logic [7:0]  c [7];
      logic [31:0] d [7];
      logic [31:0] p [7];
      logic [3:0]  f [7];
      exp_t e;
      c = '{C_PEN, C_INC, C_CAL | C_PEN, C_INC, C_CAL | C_PEN, C_RET, C_RET};
      d = '{32'h20, 32'h0, 32'h80, 32'h0, 32'hC0, 32'h0, 32'h0};
      p = '{32'h20, 32'h21, 32'h80, 32'h81, 32'hC0, 32'h81, 32'h21};
      f = '{F_E, F_E, F_0, F_0, F_0, F_0, F_E};
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back('{pc: p[i], fl: f[i]});
         cyc(c[i], d[i]);
         e = exp_q.pop_front();
         checks++;
         if (bus32.PC_data_out !== e.pc) begin
            errors++;
            $display("FAIL call_ret[%0d] pc: got %h want %h", i, bus32.PC_data_out, e.pc);
         end
         checks++;
         if (fl32 !== e.fl) begin
            errors++;
            $display("FAIL call_ret[%0d] flags: got %b want %b", i, fl32, e.fl);
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0]  c [11];
      logic [31:0] d [11];
      logic [31:0] p [11];
      logic [3:0]  f [11];
      exp_t e;
      c = '{C_PEN, C_CAL | C_PEN, C_CAL | C_PEN, C_CAL | C_PEN, C_CAL | C_PEN, C_CAL | C_PEN,
            C_RET, C_RET, C_RET, C_RET, C_RET};
      d = '{32'h1A0, 32'h1B0, 32'h1C0, 32'h1D0, 32'h1E0, 32'h1F0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      p = '{32'h1A0, 32'h1B0, 32'h1C0, 32'h1D0, 32'h1E0, 32'h1F0,
            32'h1E0, 32'h1D0, 32'h1C0, 32'h1B0, 32'h1B0};
      f = '{F_E, F_0, F_0, F_0, 4'b0100, 4'b0110,
            4'b0010, 4'b0010, 4'b0010, 4'b1010, 4'b1011};
      for (int i = 0; i < 11; i++) begin
         exp_q.push_back('{pc: p[i], fl: f[i]});
         cyc(c[i], d[i]);
         e = exp_q.pop_front();
         checks++;
         if (bus32.PC_data_out !== e.pc) begin
            errors++;
            $display("FAIL overflow[%0d] pc: got %h want %h", i, bus32.PC_data_out, e.pc);
         end
         checks++;
         if (fl32 !== e.fl) begin
            errors++;
            $display("FAIL overflow[%0d] flags: got %b want %b", i, fl32, e.fl);
         end
      end
   endtask

   task automatic test_priority_stall();
      logic [7:0]  c [7];
      logic [31:0] d [7];
      logic [31:0] p [7];
      logic [3:0]  f [7];
      exp_t e;
      c = '{C_RST, C_PEN, C_CAL | C_PEN, C_STL | C_RET | C_PEN | C_INC,
            C_STL | C_CAL | C_PEN, C_RET | C_PEN | C_CAL, C_STL | C_RET};
      d = '{32'h0, 32'h50, 32'h60, 32'h99, 32'h99, 32'h77, 32'h0};
      p = '{32'h100, 32'h50, 32'h60, 32'h60, 32'h60, 32'h50, 32'h50};
      f = '{F_E, F_E, F_0, F_0, F_0, F_E, F_E};
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back('{pc: p[i], fl: f[i]});
         cyc(c[i], d[i]);
         e = exp_q.pop_front();
         checks++;
         if (bus32.PC_data_out !== e.pc) begin
            errors++;
            $display("FAIL prio_stall[%0d] pc: got %h want %h", i, bus32.PC_data_out, e.pc);
         end
         checks++;
         if (fl32 !== e.fl) begin
            errors++;
            $display("FAIL prio_stall[%0d] flags: got %b want %b", i, fl32, e.fl);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0]  c [4];
      logic [31:0] d [4];
      logic [31:0] p [4];
      logic [3:0]  f [4];
      exp_t e;
      c = '{C_CAL | C_PEN, C_RST | C_CAL | C_PEN, C_RET, C_RST | C_RET};
      d = '{32'h80, 32'h90, 32'h0, 32'h0};
      p = '{32'h80, 32'h100, 32'h100, 32'h100};
      f = '{F_0, F_E, 4'b1001, F_E};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{pc: p[i], fl: f[i]});
         cyc(c[i], d[i]);
         e = exp_q.pop_front();
         checks++;
         if (bus32.PC_data_out !== e.pc) begin
            errors++;
            $display("FAIL reset_mid[%0d] pc: got %h want %h", i, bus32.PC_data_out, e.pc);
         end
         checks++;
         if (fl32 !== e.fl) begin
            errors++;
            $display("FAIL reset_mid[%0d] flags: got %b want %b", i, fl32, e.fl);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0]  c [4];
      logic [31:0] d [4];
      logic [7:0]  p [4];
      exp_t e;
      c = '{C_RST, C_PEN, C_INC, C_INC};
      d = '{32'h0, 32'hFF, 32'h0, 32'h0};
      p = '{8'h00, 8'hFF, 8'h00, 8'h01};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{pc: {24'h0, p[i]}, fl: F_E});
         cyc(c[i], d[i]);
         e = exp_q.pop_front();
         checks++;
         if (bus8.PC_data_out !== e.pc[7:0]) begin
            errors++;
            $display("FAIL wrap8[%0d] pc: got %h want %h", i, bus8.PC_data_out, e.pc[7:0]);
         end
         checks++;
         if (fl8 !== e.fl) begin
            errors++;
            $display("FAIL wrap8[%0d] flags: got %b want %b", i, fl8, e.fl);
         end
      end
   endtask

   initial begin
      bus32.stall = 1'b0; bus32.ret = 1'b0; bus32.call = 1'b0; bus32.PC_enable = 1'b0;
      bus32.PC_cond_enable = 1'b0; bus32.conOut = 1'b0; bus32.IncPC = 1'b0; bus32.BusMuxOut = '0;
      bus8.stall = 1'b0; bus8.ret = 1'b0; bus8.call = 1'b0; bus8.PC_enable = 1'b0;
      bus8.PC_cond_enable = 1'b0; bus8.conOut = 1'b0; bus8.IncPC = 1'b0; bus8.BusMuxOut = '0;
      @(posedge clock);
      test_reset();
      test_branch();
      test_call_ret();
      test_overflow();
      test_priority_stall();
      test_reset_mid();
      test_wrap();
      cyc(C_NOP, 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
